// File: rtl/conv_result_reader_if.sv
// Engine-side (conv_*) and stream-side (m_*) signals of the conv2 result reader.
// master = reader, slave = engine/downstream side.
interface conv_result_reader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 12
);
    logic              conv_rst;
    logic              conv_infer;
    logic [ADDR_W-1:0] conv_addr;
    logic [DATA_W-1:0] conv_out;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        output conv_rst, conv_infer, conv_addr, m_valid, m_data, m_last,
        input  conv_out, m_ready
    );

    modport slave (
        input  conv_rst, conv_infer, conv_addr, m_valid, m_data, m_last,
        output conv_out, m_ready
    );
endinterface

// File: rtl/conv_result_reader.sv
// Sequences the conv2 engine (reset, compute window, address reads) and streams
// each result word out on a valid/ready port with last on the final word.
module conv_result_reader #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 12,
    parameter int NUM_OUT        = 9,
    parameter int RST_CYCLES     = 2,
    parameter int COMPUTE_CYCLES = 450,
    parameter int RD_LAT         = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    conv_result_reader_if.master bus
);
    localparam int MAX_A = (COMPUTE_CYCLES > RST_CYCLES) ? COMPUTE_CYCLES : RST_CYCLES;
    localparam int MAX_C = (MAX_A > RD_LAT) ? MAX_A : RD_LAT;
    localparam int CNT_W = $clog2(MAX_C + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OUT - 1);

    typedef enum logic [2:0] {IDLE, ENG_RST, COMPUTE, RD_WAIT, PRESENT, FIN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              conv_rst_q, conv_rst_d;
    logic              conv_infer_q, conv_infer_d;
    logic [ADDR_W-1:0] conv_addr_q, conv_addr_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_last_q, m_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            conv_rst_q   <= 1'b0;
            conv_infer_q <= 1'b0;
            conv_addr_q  <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            conv_rst_q   <= conv_rst_d;
            conv_infer_q <= conv_infer_d;
            conv_addr_q  <= conv_addr_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        conv_rst_d   = conv_rst_q;
        conv_infer_d = conv_infer_q;
        conv_addr_d  = conv_addr_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ENG_RST;
                    conv_rst_d = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    idx_d      = '0;
                end
            end
            ENG_RST: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d    = COMPUTE;
                    conv_rst_d = 1'b0;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COMPUTE: begin
                if (cnt_q == CNT_W'(COMPUTE_CYCLES - 1)) begin
                    state_d      = RD_WAIT;
                    conv_infer_d = 1'b1;
                    conv_addr_d  = idx_q;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_WAIT: begin
                // cnt counts edges since the address was driven; capture once the engine latency has elapsed
                if (cnt_q == CNT_W'(RD_LAT)) begin
                    state_d   = PRESENT;
                    m_valid_d = 1'b1;
                    m_data_d  = bus.conv_out;
                    m_last_d  = (idx_q == LAST_IDX);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESENT: begin
                if (bus.m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    cnt_d     = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d      = FIN;
                        conv_infer_d = 1'b0;
                        conv_addr_d  = '0;
                        done_d       = 1'b1;
                    end else begin
                        state_d     = RD_WAIT;
                        idx_d       = idx_q + ADDR_W'(1);
                        conv_addr_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.conv_rst   = conv_rst_q;
    assign bus.conv_infer = conv_infer_q;
    assign bus.conv_addr  = conv_addr_q;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = m_data_q;
    assign bus.m_last     = m_last_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_conv_result_reader.sv
// Randomized scoreboard bench for conv_result_reader: a queue of expected words
// (100 + 3*addr) is filled per frame and drained by a monitor on accepted beats.
module tb_conv_result_reader;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 12;
    localparam int NUM_OUT = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic busy, done, busy2, done2;

    conv_result_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus  ();
    conv_result_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();

    conv_result_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_OUT(NUM_OUT),
        .RST_CYCLES(2), .COMPUTE_CYCLES(8), .RD_LAT(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus)
    );

    conv_result_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_OUT(1),
        .RST_CYCLES(2), .COMPUTE_CYCLES(8), .RD_LAT(0)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .bus(bus2)
    );

    always #5 clk = ~clk;

    // Engine models: registered (latency 1) for dut, combinational (latency 0) for dut2
    always @(posedge clk) bus.conv_out <= DATA_W'(100 + 3 * int'(bus.conv_addr));
    assign bus2.conv_out = DATA_W'(100 + 3 * int'(bus2.conv_addr));
    assign bus2.m_ready  = 1'b1;

    typedef struct {
        int data;
        bit last;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int done2_cnt = 0;
    int words2 = 0;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int outs1();
        return int'({bus.conv_rst, bus.conv_infer, bus.conv_addr, bus.m_valid,
                     bus.m_data, bus.m_last, busy, done});
    endfunction

    // Monitor / scoreboard
    bit pv = 0, pr = 0, prst = 1, pl = 0;
    int pd = 0;
    always @(negedge clk) begin
        if (bus.m_valid && bus.m_ready && !rst) begin
            if (exp_q.size() == 0) chk("unexpected word", int'(bus.m_data), -1);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("m_data", int'(bus.m_data), e.data);
                chk("m_last", int'(bus.m_last), int'(e.last));
            end
        end
        if (!bus.m_valid && bus.m_last) chk("m_last without valid", 1, 0);
        if (pv && !pr && !prst) begin
            chk("hold m_valid", int'(bus.m_valid), 1);
            chk("hold m_data", int'(bus.m_data), pd);
            chk("hold m_last", int'(bus.m_last), int'(pl));
        end
        if (pv && pr && !prst) chk("no back-to-back valid", int'(bus.m_valid), 0);
        if (done) done_cnt++;
        if (bus2.m_valid) begin
            words2++;
            chk("d2 m_data", int'(bus2.m_data), 100);
            chk("d2 m_last", int'(bus2.m_last), 1);
        end
        if (done2) done2_cnt++;
        pv   = bus.m_valid;
        pr   = bus.m_ready;
        prst = rst;
        pd   = int'(bus.m_data);
        pl   = bus.m_last;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int k = 0; k < NUM_OUT; k++) begin
            exp_t e;
            e.data = 100 + 3 * k;
            e.last = (k == NUM_OUT - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int d0;
        int i;
        d0 = done_cnt;
        i = 0;
        while (done_cnt == d0 && i < budget) begin
            if (rnd) bus.m_ready = 1'($urandom_range(0, 1));
            tick();
            i++;
        end
        chk("frame done within budget", int'(done_cnt != d0), 1);
    endtask

    initial begin
        int rst_hi, gap, last_v, cyc, d0, i;
        bit seen_infer, dn;
        void'($urandom(32'd20240611));
        bus.m_ready = 1'b1;

        // 1: reset with start held, then idle
        rst = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        rst = 1'b0;
        chk("outputs after reset", outs1(), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle outputs", outs1(), 0);
        end

        // 2: one frame with m_ready high, timing checks
        push_frame();
        pulse_start();
        rst_hi = 0; gap = 0; last_v = -1; cyc = 0; seen_infer = 0; dn = 0;
        while (cyc < 200 && !dn) begin
            if (bus.conv_rst) rst_hi++;
            if (bus.conv_infer) seen_infer = 1;
            if (busy && !bus.conv_rst && !seen_infer) gap++;
            if (bus.m_valid) begin
                if (last_v >= 0) chk("word spacing", cyc - last_v, 3);
                last_v = cyc;
            end
            if (done) dn = 1;
            tick();
            cyc++;
        end
        chk("done seen", int'(dn), 1);
        chk("conv_rst cycles", rst_hi, 2);
        chk("compute cycles", gap, 8);
        chk("busy after done", int'(busy), 0);
        chk("frame drained", exp_q.size(), 0);

        // 3: random back-pressure
        push_frame();
        pulse_start();
        wait_done(800, 1'b1);
        bus.m_ready = 1'b1;
        tick();
        chk("random frame drained", exp_q.size(), 0);

        // 4: start re-pulsed during COMPUTE, PRESENT and the done cycle
        d0 = done_cnt;
        push_frame();
        pulse_start();
        repeat (4) tick();
        chk("in compute", int'(busy && !bus.conv_rst && !bus.conv_infer), 1);
        pulse_start();
        bus.m_ready = 1'b0;
        i = 0;
        while (!bus.m_valid && i < 50) begin tick(); i++; end
        chk("word presented", int'(bus.m_valid), 1);
        pulse_start();
        bus.m_ready = 1'b1;
        i = 0;
        while (!done && i < 200) begin tick(); i++; end
        chk("done reached", int'(done), 1);
        pulse_start();
        repeat (20) tick();
        chk("idle after restart attempts", int'(busy), 0);
        chk("single done", done_cnt - d0, 1);
        chk("restart frame drained", exp_q.size(), 0);

        // 5: reset while word 4 is presented
        push_frame();
        bus.m_ready = 1'b0;
        pulse_start();
        i = 0;
        while (i < 300 && !(bus.m_valid && bus.m_data == 12'd112)) begin
            if (bus.m_valid) begin
                bus.m_ready = 1'b1;
                tick();
                bus.m_ready = 1'b0;
            end else tick();
            i++;
        end
        chk("words before abort", exp_q.size(), NUM_OUT - 4);
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("outputs after abort", outs1(), 0);
        exp_q.delete();
        repeat (3) tick();
        chk("no done on abort", done_cnt - d0, 0);
        bus.m_ready = 1'b1;
        push_frame();
        pulse_start();
        wait_done(300, 1'b0);
        tick();
        chk("post-abort frame drained", exp_q.size(), 0);

        // 6: RD_LAT=0, NUM_OUT=1 build
        chk("d2 idle words", words2, 0);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        i = 0;
        while (done2_cnt == 0 && i < 100) begin tick(); i++; end
        tick();
        chk("d2 done count", done2_cnt, 1);
        chk("d2 word count", words2, 1);
        chk("d2 busy", int'(busy2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
